// File: rtl/pixel_request_sequencer.sv
// Pixel request sequencer.
// On each frame start, walks a GRID_W x GRID_H grid. For each position it runs
// a four-phase request/ack handshake with software over the NIOS PIOs and
// writes the returned colour into the frame-buffer RAM.
// The wait counter bounds both ack phases so that a silent or stuck
// responder cannot hang the sequencer.

module pixel_request_sequencer #(
    parameter int GRID_W  = 160,
    parameter int GRID_H  = 120,
    parameter int ADDR_W  = 15,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk_clk,
    input  logic              reset_n,
    input  logic              frame_start,
    output logic [31:0]       pixel_position,
    output logic              pixel_request,
    input  logic              pixel_ack,
    input  logic [23:0]       pixel_color,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [23:0]       fb_wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              timeout_err
);

    // The wait counter only has to reach TIMEOUT-1, because the
    // TIMEOUT-th waiting cycle is the one that takes the timeout branch.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [15:0]       X_LAST    = 16'(GRID_W - 1);
    localparam logic [15:0]       Y_LAST    = 16'(GRID_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_RELEASE,
        S_NEXT
    } state_t;

    state_t            state;
    logic [15:0]       x_pos;
    logic [15:0]       y_pos;
    logic [ADDR_W-1:0] addr;
    logic [WAIT_W-1:0] wait_cnt;
    logic [23:0]       captured_color;

    // The position, address and data outputs are taken straight from their
    // holding registers. They therefore stay stable from the rise of the
    // request until the write cycle.
    assign pixel_position = {y_pos, x_pos};
    assign fb_wr_addr     = addr;
    assign fb_wr_data     = captured_color;

    // Handshake state machine. All outputs are registered here, so each
    // output is valid during the state it belongs to.
    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            x_pos          <= '0;
            y_pos          <= '0;
            addr           <= '0;
            wait_cnt       <= '0;
            captured_color <= '0;
            pixel_request  <= 1'b0;
            fb_wr_en       <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
            timeout_err    <= 1'b0;
        end else begin
            fb_wr_en   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state         <= S_REQ;
                        x_pos         <= '0;
                        y_pos         <= '0;
                        addr          <= '0;
                        wait_cnt      <= '0;
                        pixel_request <= 1'b1;
                        busy          <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (pixel_ack || (wait_cnt == WAIT_LAST)) begin
                        captured_color <= pixel_ack ? pixel_color : 24'h000000;
                        if (!pixel_ack) begin
                            timeout_err <= 1'b1;
                        end
                        state         <= S_WRITE;
                        fb_wr_en      <= 1'b1;
                        pixel_request <= 1'b0;
                        wait_cnt      <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_WRITE: begin
                    state    <= S_RELEASE;
                    wait_cnt <= '0;
                end

                S_RELEASE: begin
                    if (!pixel_ack) begin
                        state    <= S_NEXT;
                        wait_cnt <= '0;
                        if ((x_pos == X_LAST) && (y_pos == Y_LAST)) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_NEXT: begin
                    wait_cnt <= '0;
                    if ((x_pos == X_LAST) && (y_pos == Y_LAST)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (x_pos == X_LAST) begin
                            x_pos <= '0;
                            y_pos <= y_pos + 16'd1;
                        end else begin
                            x_pos <= x_pos + 16'd1;
                        end
                        addr          <= addr + 1'b1;
                        state         <= S_REQ;
                        pixel_request <= 1'b1;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    pixel_request <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pixel_request_sequencer.md
Name: pixel_request_sequencer

Overview:
- Sits between the VGA timing generator and the NIOS II pixel PIOs.
- On each frame start it walks a low-res GRID_W x GRID_H grid and presents each pixel position to software on the pixel position/request PIOs.
- It waits for software's acknowledge, then captures the 24-bit colour returned on the pixel colour PIO.
- Each result is written into the external frame-buffer RAM that the VGA scan-out reads.

Parameters:
- GRID_W, 160, grid width in pixels (2..65535)
- GRID_H, 120, grid height in pixels (2..65535)
- ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H
- TIMEOUT, 65535, max cycles to wait in either ack phase (>= 1)

Ports:
- clk_clk  in  1  system clock, same domain as the PIOs
- reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse from the VGA timing generator at vsync
- pixel_position  out  32  [15:0]=x, [31:16]=y; drives the pixel position PIO input
- pixel_request  out  1  drives the request PIO input
- pixel_ack  in  1  acknowledge from a software-written PIO bit
- pixel_color  in  24  colour from the pixel colour PIO output, {R,G,B}
- fb_wr_en  out  1  frame-buffer write strobe
- fb_wr_addr  out  ADDR_W  y*GRID_W+x
- fb_wr_data  out  24  colour to write
- busy  out  1  high when state != IDLE
- frame_done  out  1  one-cycle pulse when the last pixel is written
- frame_count  out  8  completed frames, wraps 255->0
- timeout_err  out  1  sticky; cleared only by reset

Behaviour:
Reset:
- Reset is asynchronous and active-low.
- While reset_n=0, every output is 0 and the state is IDLE.
- Position counters, address counter and captured colour are also 0.
- Reset taken mid-frame abandons the frame with no further write; frame_count is not incremented.

Handshake:
- Four-phase. Request rises with position already stable.
- Position is held constant from request rise until the pixel's write cycle.
- Software raises ack after placing the colour on pixel_color.
- Request falls; software drops ack; the sequencer advances.
- All inputs are sampled on the rising clock edge. No synchroniser: all inputs are in the clk_clk domain.

States:
- IDLE: request=0. frame_start=1 -> REQ; x, y and addr cleared; pixel_position={16'd0,16'd0}, request=1 on the next cycle.
- REQ: request=1.
  - ack=1 at edge t -> capture pixel_color; go to WRITE.
  - Wait counter reaching TIMEOUT -> captured colour=24'h000000; timeout_err set; go to WRITE.
- WRITE: exactly one cycle.
  - fb_wr_en=1, fb_wr_addr=current addr, fb_wr_data=captured colour, request=0.
  - Then go to RELEASE.
- RELEASE: wait for ack=0, then go to NEXT.
  - If ack stays 1 for TIMEOUT cycles: set timeout_err, abort to IDLE; no frame_done, no count increment.
- NEXT: one cycle.
  - If x==GRID_W-1 and y==GRID_H-1: frame_done=1, frame_count+1, go to IDLE.
  - Else if x==GRID_W-1: x=0, y+1, addr+1, go to REQ.
  - Else: x+1, addr+1, go to REQ.

Timing and arithmetic:
- Minimum per-pixel cost is 4 cycles (REQ with ack already high, WRITE, RELEASE with ack low, NEXT).
- The address is an incrementing counter; no multiplier.
- The wait counter resets on every state entry.
- frame_start is ignored whenever busy=1. Frames never overlap or restart.
- frame_start arriving in the same cycle as NEXT->IDLE is ignored; it is only accepted when the state is IDLE.
- pixel_color is captured only on the cycle ack is first seen high in REQ. Later changes do not affect the write.

Test Plan:
- Reset: hold reset_n=0 while driving frame_start=1 -> all outputs 0. Release, then one frame_start pulse -> request=1 with position 0x00000000 on the next cycle.
- Full frame, GRID_W=4, GRID_H=2, responder acks 3 cycles after request, colour=0x100000+addr:
  - 8 writes, addr 0..7, data 0x100000..0x100007.
  - Position 0x00010003 precedes addr 7.
  - frame_done pulses once; frame_count=1; busy falls.
- Timeout, TIMEOUT=16: responder never acks pixel (1,0) -> after 16 REQ cycles, write addr 1 data 0x000000, timeout_err=1; frame still completes with frame_count=1.
- Stuck ack: ack held high after pixel 2 -> after TIMEOUT cycles in RELEASE, state goes IDLE; busy=0; no frame_done; frame_count unchanged; timeout_err=1.
- Ignored start: frame_start pulses mid-frame and coincident with frame_done -> exactly one frame written; the next frame starts only on a later pulse.
- Async reset: reset_n asserted mid-cycle during WRITE -> fb_wr_en and request drop immediately, without waiting for a clock edge; next frame restarts at addr 0.
